// File: rtl/usiq_packetizer_pkg.sv
// Shared definitions for the USIQ byte packetizer: FSM states, default
// frame constants and the sample-to-byte selector.
package usiq_packetizer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC0  = 3'd1,
    SYNC1  = 3'd2,
    SYNC2  = 3'd3,
    STATUS = 3'd4,
    DATA   = 3'd5
  } usiq_state_e;

  localparam int          USIQ_NSAMPLES_DEF = 63;
  localparam logic [7:0]  USIQ_SYNC_DEF     = 8'h7F;
  localparam int          USIQ_CNT_W        = 9;

  // Bytes leave MSB first: index 0 is bits [23:16].
  function automatic logic [7:0] usiq_sample_byte(input logic [23:0] smp,
                                                  input logic [1:0]  idx);
    case (idx)
      2'd0:    return smp[23:16];
      2'd1:    return smp[15:8];
      default: return smp[7:0];
    endcase
  endfunction

endpackage

// File: rtl/usiq_packetizer.sv
// Frames 24-bit IQ samples from a showahead FIFO into a byte stream:
// 3 sync bytes, a status byte {seq, tuser}, then NSAMPLES x 3 data bytes.
module usiq_packetizer
  import usiq_packetizer_pkg::*;
#(
  parameter int         NSAMPLES = USIQ_NSAMPLES_DEF,
  parameter logic [7:0] SYNC     = USIQ_SYNC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [23:0] us_tdata,
  input  logic        us_tvalid,
  output logic        us_tready,
  input  logic [1:0]  us_tuser,
  input  logic [10:0] us_tlength,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic        underflow
);

  localparam logic [USIQ_CNT_W-1:0] LAST_SMP = USIQ_CNT_W'(NSAMPLES - 1);
  localparam logic [10:0]           NEED     = 11'(NSAMPLES);

  usiq_state_e           state_q, state_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [USIQ_CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]            seq_q, seq_d;
  logic [7:0]            status_q, status_d;
  logic [23:0]           smp_q, smp_d;
  logic                  ok_q, ok_d;
  logic                  cap_q, cap_d;
  logic                  unf_q, unf_d;
  logic [10:0]           len_q, len_d;

  logic        hs;
  logic        pop;
  logic        last_byte;
  logic [23:0] cur_smp;

  // The first cycle of byte 0 shows the live FIFO head; from then on the
  // captured copy is used so a late us_tvalid cannot change a stalled byte.
  always_comb begin
    cur_smp   = cap_q ? smp_q : (us_tvalid ? us_tdata : 24'h0);
    hs        = (state_q != IDLE) && tx_tready;
    last_byte = (state_q == DATA) && (bidx_q == 2'd2) && (cnt_q == LAST_SMP);
    pop       = hs && (state_q == DATA) && (bidx_q == 2'd2) && ok_q && us_tvalid;
  end

  always_comb begin
    tx_tvalid = (state_q != IDLE);
    tx_tlast  = last_byte;
    us_tready = pop;
    underflow = unf_q;
    tx_tdata  = 8'h00;
    case (state_q)
      SYNC0, SYNC1, SYNC2: tx_tdata = SYNC;
      STATUS:              tx_tdata = status_q;
      DATA:                tx_tdata = usiq_sample_byte(cur_smp, bidx_q);
      default:             tx_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    status_d = status_q;
    smp_d    = smp_q;
    ok_d     = ok_q;
    cap_d    = cap_q;
    unf_d    = unf_q;
    // A pop in flight makes the FIFO count stale; force one IDLE look-ahead miss.
    len_d    = pop ? 11'd0 : us_tlength;

    if (state_q == DATA && !cap_q) begin
      cap_d = 1'b1;
      smp_d = cur_smp;
      ok_d  = us_tvalid;
      if (!us_tvalid) unf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cap_d = 1'b0;
        if (run && (len_q >= NEED)) begin
          state_d  = SYNC0;
          status_d = {seq_q, us_tuser};
        end
      end
      SYNC0:  if (hs) state_d = SYNC1;
      SYNC1:  if (hs) state_d = SYNC2;
      SYNC2:  if (hs) state_d = STATUS;
      STATUS: begin
        if (hs) begin
          state_d = DATA;
          bidx_d  = 2'd0;
          cnt_d   = '0;
          cap_d   = 1'b0;
        end
      end
      DATA: begin
        if (hs) begin
          if (bidx_q == 2'd2) begin
            bidx_d = 2'd0;
            cap_d  = 1'b0;
            if (cnt_q == LAST_SMP) begin
              state_d = IDLE;
              seq_d   = seq_q + 6'd1;
            end else begin
              cnt_d = cnt_q + USIQ_CNT_W'(1);
            end
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bidx_q  <= 2'd0;
      cnt_q   <= '0;
      seq_q   <= 6'd0;
      ok_q    <= 1'b0;
      cap_q   <= 1'b0;
      unf_q   <= 1'b0;
      len_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      ok_q    <= ok_d;
      cap_q   <= cap_d;
      unf_q   <= unf_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk) begin
    status_q <= status_d;
    smp_q    <= smp_d;
  end

endmodule

// File: tb/tb_usiq_packetizer.sv
// Self-checking bench for usiq_packetizer with NSAMPLES=2: a queue-based FIFO
// model feeds the DUT and expected frames are assembled from the framing rules.
module tb_usiq_packetizer;

  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [23:0] us_tdata;
  logic        us_tvalid, us_tready;
  logic [1:0]  us_tuser;
  logic [10:0] us_tlength;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tready, tx_tlast, underflow;

  int checks = 0;
  int errors = 0;

  logic [23:0] fifo[$];
  bit          force_inval = 0, arm_inval = 0, rand_ready = 0;
  int          len_ovr = -1;
  logic [7:0]  obs_b[$], exp_b[$];
  bit          obs_l[$], exp_l[$];
  int          npops = 0, nlasts = 0;
  bit          saw_valid = 0, stall_prev = 0;
  logic [7:0]  held_d;
  logic        held_l;
  logic [23:0] smp[$];

  usiq_packetizer #(.NSAMPLES(NS), .SYNC(8'h7F)) dut (
    .clk(clk), .rst(rst), .run(run),
    .us_tdata(us_tdata), .us_tvalid(us_tvalid), .us_tready(us_tready),
    .us_tuser(us_tuser), .us_tlength(us_tlength),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tlast(tx_tlast), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    us_tvalid  = (fifo.size() > 0) && !force_inval;
    us_tdata   = (fifo.size() > 0) ? fifo[0] : 24'h0;
    us_tlength = (len_ovr >= 0) ? 11'(len_ovr) : 11'(fifo.size());
    tx_tready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    bit do_pop;
    @(negedge clk);
    if (stall_prev && !rst) begin
      chk("hold_valid", tx_tvalid, 1'b1);
      chk("hold_data", tx_tdata, held_d);
      chk("hold_last", tx_tlast, held_l);
    end
    stall_prev = tx_tvalid && !tx_tready;
    held_d = tx_tdata;
    held_l = tx_tlast;
    if (tx_tvalid) saw_valid = 1;
    if (tx_tvalid && tx_tready) begin
      obs_b.push_back(tx_tdata);
      obs_l.push_back(tx_tlast);
      if (tx_tlast) nlasts++;
    end
    do_pop = us_tready;
    if (us_tready) begin
      npops++;
      chk("pop_needs_valid", us_tvalid, 1'b1);
    end
    @(posedge clk);
    #1;
    if (do_pop && !rst && fifo.size() > 0) begin
      void'(fifo.pop_front());
      if (arm_inval) begin
        force_inval = 1;
        arm_inval   = 0;
      end
    end
    drive();
  endtask

  task automatic clear_logs();
    obs_b.delete(); obs_l.delete(); exp_b.delete(); exp_l.delete();
    npops = 0; nlasts = 0; saw_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; run = 0; stall_prev = 0; drive();
    tick(); tick();
    rst = 0; drive();
    clear_logs();
  endtask

  // Frame model: 3 sync bytes, status {seq mod 64, tuser}, samples MSB first,
  // zeros for a sample that was missing at its first byte, tlast on the end.
  task automatic add_frame(input int seq, input logic [1:0] tu,
                           input logic [23:0] s0, input logic [23:0] s1,
                           input bit bad0, input bit bad1);
    logic [23:0] s [NS];
    bit          bad [NS];
    s[0] = bad0 ? 24'h0 : s0;  bad[0] = bad0;
    s[1] = bad1 ? 24'h0 : s1;  bad[1] = bad1;
    for (int i = 0; i < 3; i++) begin exp_b.push_back(8'h7F); exp_l.push_back(0); end
    exp_b.push_back({6'(seq % 64), tu}); exp_l.push_back(0);
    for (int k = 0; k < NS; k++) begin
      exp_b.push_back(s[k][23:16]); exp_l.push_back(0);
      exp_b.push_back(s[k][15:8]);  exp_l.push_back(0);
      exp_b.push_back(s[k][7:0]);   exp_l.push_back(k == NS - 1);
    end
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_nbytes"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), obs_b[i], exp_b[i]);
      chk($sformatf("%s_last%0d", tag, i), obs_l[i], exp_l[i]);
    end
  endtask

  task automatic wait_lasts(input string tag, input int n, input int budget);
    int c = 0;
    while (nlasts < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_frames_done"}, nlasts, n);
  endtask

  initial begin
    int c;
    rst = 1; run = 0; us_tuser = 2'd0; tx_tready = 1;
    drive();

    // Reset state
    do_reset();
    chk("rst_tvalid", tx_tvalid, 1'b0);
    chk("rst_tlast", tx_tlast, 1'b0);
    chk("rst_tdata", tx_tdata, 8'h00);
    chk("rst_tready", us_tready, 1'b0);
    chk("rst_underflow", underflow, 1'b0);

    // Basic frame of two known samples
    fifo = '{24'h123456, 24'hABCDEF};
    us_tuser = 2'd2; run = 1; drive();
    wait_lasts("basic", 1, 40);
    run = 0; drive();
    add_frame(0, 2'd2, 24'h123456, 24'hABCDEF, 0, 0);
    cmp_frames("basic");
    chk("basic_pops", npops, 2);
    chk("basic_underflow", underflow, 1'b0);

    // 65 back-to-back frames of random samples: seq 0,1,2 ... 63, 0
    do_reset();
    smp.delete();
    for (int i = 0; i < 65 * NS; i++) smp.push_back(24'($urandom));
    fifo = smp;
    us_tuser = 2'd2; run = 1; drive();
    wait_lasts("b2b", 65, 65 * 20);
    run = 0; drive();
    for (int f = 0; f < 65; f++) add_frame(f, 2'd2, smp[2 * f], smp[2 * f + 1], 0, 0);
    cmp_frames("b2b");
    chk("b2b_pops", npops, 65 * NS);
    chk("b2b_status0", obs_b.size() > 3 ? obs_b[3] : 8'hXX, 8'h02);
    chk("b2b_status1", obs_b.size() > 13 ? obs_b[13] : 8'hXX, 8'h06);
    chk("b2b_status2", obs_b.size() > 23 ? obs_b[23] : 8'hXX, 8'h0A);
    chk("b2b_status_wrap", obs_b.size() > 643 ? obs_b[643] : 8'hXX, 8'h02);

    // Random backpressure: same bytes, outputs held during stalls
    do_reset();
    fifo = '{24'h123456, 24'hABCDEF};
    us_tuser = 2'd2; rand_ready = 1; run = 1; drive();
    wait_lasts("stall", 1, 200);
    rand_ready = 0; run = 0; drive();
    add_frame(0, 2'd2, 24'h123456, 24'hABCDEF, 0, 0);
    cmp_frames("stall");
    chk("stall_pops", npops, 2);

    // Start gated by the FIFO fill level
    do_reset();
    fifo = '{24'h0F1E2D, 24'h3C4B5A};
    len_ovr = 1; us_tuser = 2'd1; run = 1; drive();
    for (int i = 0; i < 10; i++) tick();
    chk("lowfill_no_start", saw_valid, 1'b0);
    len_ovr = -1; drive();
    tick();
    chk("fill_not_early", saw_valid, 1'b0);
    c = 0;
    while (!saw_valid && c < 3) begin tick(); c++; end
    chk("fill_starts", saw_valid, 1'b1);
    wait_lasts("fill", 1, 40);
    run = 0; drive();
    add_frame(0, 2'd1, 24'h0F1E2D, 24'h3C4B5A, 0, 0);
    cmp_frames("fill");

    // Missing second sample: zeros, underflow, length kept, one pop
    do_reset();
    smp.delete();
    smp.push_back(24'($urandom)); smp.push_back(24'($urandom));
    fifo = smp;
    arm_inval = 1; us_tuser = 2'd3; run = 1; drive();
    wait_lasts("unf", 1, 40);
    run = 0; force_inval = 0; arm_inval = 0; drive();
    add_frame(0, 2'd3, smp[0], smp[1], 0, 1);
    cmp_frames("unf");
    chk("unf_pops", npops, 1);
    chk("unf_flag", underflow, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("unf_sticky", underflow, 1'b1);
    chk("unf_idle", tx_tvalid, 1'b0);

    // Reset mid-frame at byte 5, then a clean frame with seq back at 0
    clear_logs();
    fifo = '{24'hC0FFEE, 24'h5A5A5A};
    us_tuser = 2'd0; run = 1; drive();
    c = 0;
    while (obs_b.size() < 5 && c < 40) begin tick(); c++; end
    chk("midrst_reached", obs_b.size(), 5);
    rst = 1; drive();
    tick();
    chk("midrst_tvalid", tx_tvalid, 1'b0);
    chk("midrst_tlast", tx_tlast, 1'b0);
    chk("midrst_tdata", tx_tdata, 8'h00);
    chk("midrst_tready", us_tready, 1'b0);
    chk("midrst_underflow", underflow, 1'b0);
    rst = 0; stall_prev = 0;
    clear_logs();
    us_tuser = 2'd1; drive();
    wait_lasts("after_rst", 1, 40);
    run = 0; drive();
    add_frame(0, 2'd1, 24'hC0FFEE, 24'h5A5A5A, 0, 0);
    cmp_frames("after_rst");
    chk("after_rst_pops", npops, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usiq_packetizer.md
USIQ_PACKETIZER -- requirements
Module: usiq_packetizer

Interface
REQ-001 SHALL have parameter NSAMPLES, default 63, giving the number of 24-bit samples per frame (range 1..340).
REQ-002 SHALL have parameter SYNC, default 8'h7F, giving the sync byte value.
REQ-003 SHALL have port clk  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port run  in  1  frame-start enable.
REQ-006 SHALL have port us_tdata  in  24  sample from the showahead upstream IQ FIFO read side.
REQ-007 SHALL have port us_tvalid  in  1  FIFO not empty.
REQ-008 SHALL have port us_tready  out  1  pop strobe (FIFO rdreq).
REQ-009 SHALL have port us_tuser  in  2  per-sample user bits.
REQ-010 SHALL have port us_tlength  in  11  FIFO read-side used-word count.
REQ-011 SHALL have port tx_tdata  out  8  output byte.
REQ-012 SHALL have port tx_tvalid  out  1  output byte valid.
REQ-013 SHALL have port tx_tready  in  1  downstream accept.
REQ-014 SHALL have port tx_tlast  out  1  last byte of frame.
REQ-015 SHALL have port underflow  out  1  sticky flag: a sample was missing mid-frame.

Function
REQ-016 SHALL emit each frame as: 3 x SYNC, one status byte, then NSAMPLES x 3 data bytes (MSB first); frame length = 4+3*NSAMPLES bytes.
REQ-017 SHALL form the status byte as {seq[5:0], us_tuser} sampled at frame start; seq is a 6-bit frame counter that increments after each tlast handshake and wraps 63->0.
REQ-018 SHALL implement states IDLE, SYNC0, SYNC1, SYNC2, STATUS, DATA.
REQ-019 SHALL in IDLE move to SYNC0 when run=1 and us_tlength >= NSAMPLES; the first byte SHALL be valid on the next cycle.
REQ-020 SHALL advance state, byte index (0..2) or sample count only on a tx_tvalid & tx_tready cycle.
REQ-021 SHALL hold tx_tdata, tx_tvalid and tx_tlast stable while tx_tvalid=1 and tx_tready=0.
REQ-022 SHALL assert us_tready for exactly one cycle per sample, on the handshake of byte index 2, and only if us_tvalid=1.
REQ-023 SHALL, if us_tvalid=0 at the first byte of a sample, send 8'h00 for all 3 bytes of that sample, not pop, set underflow, and keep the frame length unchanged.
REQ-024 SHALL assert tx_tlast only on the final data byte; after that handshake it SHALL return to IDLE with no idle cycle required beyond the start condition.
REQ-025 SHALL complete any frame in progress when run falls; the next frame SHALL then not start.
REQ-026 SHALL not start a new frame when us_tlength >= NSAMPLES is true only because of a pending pop; the check uses registered us_tlength, and one IDLE cycle between frames is required.
REQ-027 SHALL, once set, clear underflow only on rst.

Reset
REQ-028 SHALL on rst, in any state including mid-frame, set state=IDLE, tx_tvalid=0, tx_tlast=0, tx_tdata=0, us_tready=0, seq=0 and underflow=0; a partial frame is abandoned with no tlast.

Structure
REQ-029 SHALL place the state enum and the default SYNC/NSAMPLES constants in the shared gateware package.
REQ-030 SHALL be a single module with no sub-modules; the byte mux is inline.

Verification
REQ-031 NSAMPLES=2, FIFO holding 0x123456 and 0xABCDEF with tuser=2, run=1, tx_tready=1 -> bytes 7F 7F 7F 02 12 34 56 AB CD EF, tlast on EF, two us_tready pulses.
REQ-032 Back-to-back frames -> status bytes 02, 06, 0A (seq 0,1,2), and seq wraps to 0 after the 64th frame.
REQ-033 tx_tready toggled randomly -> byte sequence identical to REQ-031 with outputs stable during stalls.
REQ-034 us_tlength=1 with NSAMPLES=2 -> no tx_tvalid; raising the count to 2 -> frame starts one cycle later.
REQ-035 us_tvalid forced low at sample 2 -> bytes 00 00 00, underflow=1, tlast still on byte 10, no pop.
REQ-036 rst asserted at byte 5 -> tx_tvalid=0 next cycle, seq=0, next frame begins with 7F 7F 7F 00|tuser.
